// File: rtl/mem_wb_reg_pkg.sv
// Shared types and defaults for the MEM/WB pipeline register.
package mem_wb_reg_pkg;

  localparam int unsigned DefaultDataW   = 16;
  localparam int unsigned DefaultRegW    = 3;
  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned DefaultCntW    = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mem_wb_state_e;

  // Writeback control bits carried alongside an instruction parked on a miss.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic halt;
  } wb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: parks an instruction across a cache miss, inserts
// bubbles into writeback meanwhile, and keeps access/hit statistics.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned REG_W   = DefaultRegW,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] read_data_out,
  input  logic              Done,
  input  logic              CacheHit,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  input  logic              halt_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              RegWrite_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              halt_out,
  output logic              mem_stall,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  mem_wb_state_e state_q, state_d;

  wb_ctrl_t          hold_ctrl_q, hold_ctrl_d;
  logic [REG_W-1:0]  hold_wreg_q, hold_wreg_d;
  logic [DATA_W-1:0] hold_alu_q, hold_alu_d;

  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic              halt_q, halt_d;

  logic memop;
  logic done_accept;
  logic hit_inc;

  assign memop = valid_in & (MemRead | MemWrite);

  always_comb begin
    state_d     = state_q;
    hold_ctrl_d = hold_ctrl_q;
    hold_wreg_d = hold_wreg_q;
    hold_alu_d  = hold_alu_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    valid_d     = 1'b0;
    wb_data_d   = wb_data_q;
    reg_write_d = 1'b0;
    write_reg_d = write_reg_q;
    halt_d      = 1'b0;
    done_accept = 1'b0;
    mem_stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_in && !memop) begin
          valid_d     = 1'b1;
          wb_data_d   = ALU_result;
          reg_write_d = RegWrite_in;
          write_reg_d = WriteReg_in;
          halt_d      = halt_in;
        end else if (memop && Done) begin
          valid_d     = 1'b1;
          wb_data_d   = MemToReg_in ? read_data_out : ALU_result;
          reg_write_d = RegWrite_in;
          write_reg_d = WriteReg_in;
          halt_d      = halt_in;
          done_accept = 1'b1;
        end else if (memop) begin
          // Miss: snapshot everything now, upstream inputs are ignored until Done.
          state_d                = StBusy;
          hold_ctrl_d.reg_write  = RegWrite_in;
          hold_ctrl_d.mem_to_reg = MemToReg_in;
          hold_ctrl_d.halt       = halt_in;
          hold_wreg_d            = WriteReg_in;
          hold_alu_d             = ALU_result;
          wait_cnt_d             = '0;
          mem_stall              = 1'b1;
        end
      end

      StBusy: begin
        if (Done) begin
          state_d     = StIdle;
          valid_d     = 1'b1;
          wb_data_d   = hold_ctrl_q.mem_to_reg ? read_data_out : hold_alu_q;
          reg_write_d = hold_ctrl_q.reg_write;
          write_reg_d = hold_wreg_q;
          halt_d      = hold_ctrl_q.halt;
          wait_cnt_d  = '0;
          done_accept = 1'b1;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
          if (wait_cnt_d == WaitMax) begin
            timeout_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign hit_inc = done_accept & CacheHit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_ctrl_q <= '0;
      hold_wreg_q <= '0;
      hold_alu_q  <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_ctrl_q <= hold_ctrl_d;
      hold_wreg_q <= hold_wreg_d;
      hold_alu_q  <= hold_alu_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      wb_data_q   <= wb_data_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      halt_q      <= halt_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_access_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (done_accept),
    .count (access_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  assign valid_out    = valid_q;
  assign wb_data      = wb_data_q;
  assign RegWrite_out = reg_write_q & valid_q;
  assign WriteReg_out = write_reg_q;
  assign halt_out     = halt_q & valid_q;
  assign timeout_err  = timeout_q;

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- Pipeline register between the memory stage and the writeback stage.
- Captures the ALU result, load data and writeback control for each instruction leaving memory.
- Absorbs multi-cycle cache misses by holding the in-flight instruction until the memory system reports Done, and sends bubbles to writeback meanwhile.
- Raises the upstream stall request and keeps hit/access/timeout statistics.

Parameters:
- DATA_W, 16, datapath width.
- REG_W, 3, register-specifier width.
- TIMEOUT, 64, maximum cycles in BUSY before the timeout error is raised.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  instruction present at the memory-stage output this cycle.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store.
- ALU_result  in  DATA_W  address or ALU value from the memory stage.
- read_data_out  in  DATA_W  load data from the memory stage.
- Done  in  1  memory operation complete; single-cycle pulse.
- CacheHit  in  1  qualifies Done.
- RegWrite_in  in  1  writeback enable.
- MemToReg_in  in  1  select load data for writeback.
- WriteReg_in  in  REG_W  destination register.
- halt_in  in  1  halt instruction.
- valid_out  out  1  writeback slot holds a real instruction.
- wb_data  out  DATA_W  selected writeback value.
- RegWrite_out  out  1  gated writeback enable (RegWrite_in & valid).
- WriteReg_out  out  REG_W  destination register.
- halt_out  out  1  halt reached writeback.
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM.
- timeout_err  out  1  sticky error flag.
- access_cnt  out  CNT_W  memory operations completed.
- hit_cnt  out  CNT_W  memory operations completed as hits.

Behaviour:
- Reset (asynchronous, any state): all registered outputs 0, counters 0, timeout_err 0, FSM to IDLE. An in-flight operation is abandoned with no capture.
- Define memop = valid_in & (MemRead | MemWrite).
- FSM states: IDLE, BUSY.
- IDLE, non-memory instruction (valid_in & !memop): register next cycle with wb_data = ALU_result and valid_out = 1.
- IDLE, memop & Done in the same cycle (hit path): register next cycle with wb_data = MemToReg_in ? read_data_out : ALU_result. No stall.
- IDLE, memop & !Done: go to BUSY. Latch the control fields (RegWrite_in, MemToReg_in, WriteReg_in, halt_in) and ALU_result into holding registers. valid_out = 0 next cycle.
- IDLE, !valid_in: valid_out = 0 next cycle.
- BUSY, each cycle without Done: valid_out = 0 (bubble); wait counter +1.
- BUSY, Done: capture read_data_out, register the held instruction with valid_out = 1 next cycle, return to IDLE, clear the wait counter.
- mem_stall = (IDLE & memop & !Done) | (BUSY & !Done). It deasserts in the Done cycle so upstream advances on that same edge.
- Upstream holds its inputs stable while mem_stall = 1. The block uses only the latched copies in BUSY.
- Done while IDLE with no memop: ignored; no counter change.
- Statistics: on every Done accepted (IDLE hit path or BUSY completion), access_cnt +1. If CacheHit is also 1, hit_cnt +1. Both saturate at all-ones and never wrap.
- Timeout: when the wait counter reaches TIMEOUT in BUSY, set timeout_err (sticky until reset). The FSM keeps waiting.
- valid_out, RegWrite_out and halt_out are 1 for exactly one cycle per retired instruction.
- Stores retire with valid_out = 1 and RegWrite_out = 0.
- Latency: hit or non-memory instruction = 1 cycle. A miss with Done N cycles after entry gives valid_out N+1 cycles after entry.

Decomposition:
- Shared package: FSM state encoding (IDLE = 1'b0, BUSY = 1'b1), DATA_W/REG_W defaults, TIMEOUT default.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output count; saturating). Instantiated twice, for access_cnt and hit_cnt.
- The wait counter stays inline.

Test Plan:
- Reset mid-miss: load enters BUSY, rst pulsed asynchronously at cycle 3 -> FSM IDLE immediately, valid_out = 0, counters 0, no stale capture after reset release.
- ALU op (valid_in = 1, memop = 0, ALU_result = 16'h1234, WriteReg = 3, RegWrite = 1) -> next cycle valid_out = 1, wb_data = 16'h1234, WriteReg_out = 3, mem_stall never asserted.
- Load hit (MemRead = 1, Done = CacheHit = 1 same cycle, read_data_out = 16'hBEEF, MemToReg = 1) -> next cycle wb_data = 16'hBEEF; access_cnt = 1, hit_cnt = 1; mem_stall = 0 throughout.
- Load miss (MemRead = 1, Done after 4 cycles with read_data_out = 16'hCAFE, CacheHit = 0) -> mem_stall high 4 cycles, 4 bubbles, then one valid_out with wb_data = 16'hCAFE; access_cnt +1, hit_cnt unchanged. Inputs changed during the stall must not corrupt WriteReg_out.
- Store miss then timeout: MemWrite = 1, Done withheld for TIMEOUT cycles -> timeout_err = 1 and stays 1. A later Done retires the store with RegWrite_out = 0.
- Saturation and spurious Done: force access_cnt to 16'hFFFF, complete another hit -> stays 16'hFFFF. Done pulse with valid_in = 0 -> no counter change, valid_out = 0.
